// File: rtl/output_buffer_read_ctrl_if.sv
// Signal bundle between the read-mode output buffer sequencer and its environment.
// master = sequencer side, slave = register block / buffer side. OUTBUF_RDCTL_ABORT_EN adds abort_i/aborted_o.
interface output_buffer_read_ctrl_if;
    logic        start_i;
    logic [6:0]  start_col_i;
    logic [7:0]  num_adc_i;
    logic        busy_o;
    logic        done_o;
    logic [8:0]  col_addr9_o;
    logic        read_mode_buf_w_en_o;
    logic        read_load_en_o;
    logic [31:0] read_mode_encoder_i;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
`ifdef OUTBUF_RDCTL_ABORT_EN
    logic        abort_i;
    logic        aborted_o;
`endif

    modport master (
`ifdef OUTBUF_RDCTL_ABORT_EN
        input  abort_i,
        output aborted_o,
`endif
        input  start_i, start_col_i, num_adc_i, read_mode_encoder_i, word_ready_i,
        output busy_o, done_o, col_addr9_o, read_mode_buf_w_en_o, read_load_en_o,
               word_o, word_valid_o
    );

    modport slave (
`ifdef OUTBUF_RDCTL_ABORT_EN
        output abort_i,
        input  aborted_o,
`endif
        output start_i, start_col_i, num_adc_i, read_mode_encoder_i, word_ready_i,
        input  busy_o, done_o, col_addr9_o, read_mode_buf_w_en_o, read_load_en_o,
               word_o, word_valid_o
    );
endinterface

// File: rtl/output_buffer_read_ctrl.sv
// Sweeps ADC slices of the read-mode output buffer, packs 4-bit results eight per word into a show-ahead FIFO.
// Optional abort support is enabled with OUTBUF_RDCTL_ABORT_EN.
module output_buffer_read_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output_buffer_read_ctrl_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_WEN  = 3'd2,
        S_LOAD = 3'd3,
        S_PUSH = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        state_q;
    logic [6:0]    adc_idx_q;
    logic [7:0]    remain_q;
    logic [2:0]    nib_q;
    logic [31:0]   pack_q;
    logic          busy_q;
    logic          done_q;
    logic          w_en_q;
    logic          load_en_q;
    logic [8:0]    col_q;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;

    logic          fifo_full_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          abort_s;
    logic [6:0]    next_idx_s;
    logic [7:0]    clamp_num_s;
    logic          unused_enc_s;

`ifdef OUTBUF_RDCTL_ABORT_EN
    logic          aborted_q;
    assign abort_s = bus.abort_i && (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.aborted_o = aborted_q;
`else
    assign abort_s = 1'b0;
`endif

    // Full is taken from registered occupancy, so a same-cycle pop never unblocks PUSH.
    assign fifo_full_s  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign fifo_push_s  = (state_q == S_PUSH) && !fifo_full_s && !abort_s;
    assign fifo_pop_s   = (count_q != (PW+1)'(0)) && bus.word_ready_i;
    assign next_idx_s   = adc_idx_q + 7'd1;
    assign clamp_num_s  = (bus.num_adc_i > 8'd128) ? 8'd128 : bus.num_adc_i;
    assign unused_enc_s = ^bus.read_mode_encoder_i[31:4];

    assign bus.busy_o               = busy_q;
    assign bus.done_o               = done_q;
    assign bus.col_addr9_o          = col_q;
    assign bus.read_mode_buf_w_en_o = w_en_q;
    assign bus.read_load_en_o       = load_en_q;
    assign bus.word_valid_o         = (count_q != (PW+1)'(0));
    assign bus.word_o               = (count_q != (PW+1)'(0)) ? mem_q[rd_ptr_q] : 32'h0000_0000;

    // Sweep sequencer with registered strobes, address and status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            adc_idx_q <= 7'd0;
            remain_q  <= 8'd0;
            nib_q     <= 3'd0;
            pack_q    <= 32'h0000_0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_en_q    <= 1'b0;
            load_en_q <= 1'b0;
            col_q     <= 9'd0;
`ifdef OUTBUF_RDCTL_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            w_en_q    <= 1'b0;
            load_en_q <= 1'b0;
`ifdef OUTBUF_RDCTL_ABORT_EN
            aborted_q <= abort_s;
`endif
            if (abort_s) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                col_q   <= 9'd0;
                pack_q  <= 32'h0000_0000;
                nib_q   <= 3'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        col_q <= 9'd0;
                        if (bus.start_i) begin
                            busy_q <= 1'b1;
                            if (bus.num_adc_i == 8'd0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                adc_idx_q <= bus.start_col_i;
                                remain_q  <= clamp_num_s;
                                nib_q     <= 3'd0;
                                pack_q    <= 32'h0000_0000;
                                col_q     <= {bus.start_col_i, 2'b00};
                                state_q   <= S_SEL;
                            end
                        end else begin
                            busy_q <= 1'b0;
                        end
                    end
                    S_SEL: begin
                        w_en_q  <= 1'b1;
                        state_q <= S_WEN;
                    end
                    S_WEN: begin
                        load_en_q <= 1'b1;
                        state_q   <= S_LOAD;
                    end
                    S_LOAD: begin
                        pack_q[{nib_q, 2'b00} +: 4] <= bus.read_mode_encoder_i[3:0];
                        remain_q  <= remain_q - 8'd1;
                        adc_idx_q <= next_idx_s;
                        if ((nib_q == 3'd7) || (remain_q == 8'd1)) begin
                            state_q <= S_PUSH;
                        end else begin
                            nib_q   <= nib_q + 3'd1;
                            col_q   <= {next_idx_s, 2'b00};
                            state_q <= S_SEL;
                        end
                    end
                    S_PUSH: begin
                        if (!fifo_full_s) begin
                            pack_q <= 32'h0000_0000;
                            nib_q  <= 3'd0;
                            if (remain_q != 8'd0) begin
                                col_q   <= {adc_idx_q, 2'b00};
                                state_q <= S_SEL;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end else begin
                            state_q <= S_PUSH;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        col_q   <= 9'd0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        col_q   <= 9'd0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {(PW+1){1'b0}};
        end else begin
            if (fifo_push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (fifo_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            case ({fifo_push_s, fifo_pop_s})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only visible through word_o while occupancy is non-zero.
    always_ff @(posedge clk_i) begin
        if (fifo_push_s) begin
            mem_q[wr_ptr_q] <= pack_q;
        end
    end
endmodule

// File: tb/tb_output_buffer_read_ctrl.sv
// Self-checking bench for output_buffer_read_ctrl: randomized sweeps against a queue-based model of the buffer.
module tb_output_buffer_read_ctrl;
    localparam int FIFO_DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic [31:0] tbl [128];
    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    output_buffer_read_ctrl_if bus();

    output_buffer_read_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Buffer model: every column returns its table entry; only the low nibble is meaningful.
    assign bus.read_mode_encoder_i = tbl[bus.col_addr9_o[8:2]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return {20'h0, bus.busy_o, bus.done_o, bus.read_mode_buf_w_en_o, bus.read_load_en_o,
                bus.col_addr9_o, bus.word_valid_o, bus.word_o};
    endfunction

    // hold = 0: consumer always ready; hold > 0: consumer stalled until that cycle.
    task automatic run_sweep(input string tag, input int sc, input int num, input int hold,
                             output int first_valid, output logic [31:0] word0);
        int n_eff;
        int c;
        int done_cyc;
        int loads_at_hold;
        int late_strobes;
        int excl_err;
        int addr_err;
        logic [31:0] w;
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        int idx_seq[$];
        int wen_seq[$];
        int ld_seq[$];
        n_eff = (num > 128) ? 128 : num;
        w = 32'h0;
        for (int i = 0; i < n_eff; i++) begin
            idx_seq.push_back((sc + i) % 128);
            w = w | ({28'h0, tbl[(sc + i) % 128][3:0]} << (4 * (i % 8)));
            if ((i % 8 == 7) || (i == n_eff - 1)) begin
                exp_q.push_back(w);
                w = 32'h0;
            end
        end
        first_valid = -1; done_cyc = -1; loads_at_hold = -1;
        late_strobes = 0; excl_err = 0; addr_err = 0;
        bus.word_ready_i = (hold == 0);
        @(negedge clk_i);
        bus.start_i = 1'b1; bus.start_col_i = sc[6:0]; bus.num_adc_i = num[7:0];
        @(negedge clk_i);
        bus.start_i = 1'b0;
        c = 1;
        while (done_cyc < 0 && c < 3000) begin
            if (hold > 0 && c == hold) begin
                loads_at_hold = ld_seq.size();
                bus.word_ready_i = 1'b1;
            end
            if (hold > 0 && c >= hold - 50 && c < hold && (bus.read_mode_buf_w_en_o || bus.read_load_en_o))
                late_strobes++;
            if (bus.read_mode_buf_w_en_o && bus.read_load_en_o) excl_err++;
            if ((bus.read_mode_buf_w_en_o || bus.read_load_en_o) && bus.col_addr9_o[1:0] != 2'b00) addr_err++;
            if (bus.read_mode_buf_w_en_o) wen_seq.push_back(int'(bus.col_addr9_o[8:2]));
            if (bus.read_load_en_o) ld_seq.push_back(int'(bus.col_addr9_o[8:2]));
            if (bus.word_valid_o && first_valid < 0) first_valid = c;
            if (bus.word_valid_o && bus.word_ready_i) got_q.push_back(bus.word_o);
            if (bus.done_o) done_cyc = c;
            @(negedge clk_i);
            c++;
        end
        check({tag, "_done_seen"}, 64'(done_cyc > 0), 64'd1);
        if (hold == 0) check({tag, "_cycles"}, 64'(done_cyc), 64'(3 * n_eff + (n_eff + 7) / 8 + 1));
        check({tag, "_busy_after"}, 64'(bus.busy_o), 64'd0);
        check({tag, "_col_idle"}, 64'(bus.col_addr9_o), 64'd0);
        for (int k = 0; k < 20 && bus.word_valid_o; k++) begin
            got_q.push_back(bus.word_o);
            @(negedge clk_i);
        end
        if (hold > 0) begin
            check({tag, "_loads_at_stall"}, 64'(loads_at_hold), 64'(n_eff));
            check({tag, "_stall_strobes"}, 64'(late_strobes), 64'd0);
            check({tag, "_done_after_release"}, 64'(done_cyc > hold), 64'd1);
        end
        check({tag, "_wen_count"}, 64'(wen_seq.size()), 64'(n_eff));
        check({tag, "_load_count"}, 64'(ld_seq.size()), 64'(n_eff));
        for (int i = 0; i < n_eff && i < ld_seq.size() && i < wen_seq.size(); i++) begin
            if (ld_seq[i] != idx_seq[i] || wen_seq[i] != idx_seq[i]) addr_err++;
        end
        check({tag, "_addr_seq"}, 64'(addr_err), 64'd0);
        check({tag, "_strobe_excl"}, 64'(excl_err), 64'd0);
        check({tag, "_word_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({tag, "_fifo_empty"}, 64'(bus.word_valid_o), 64'd0);
        word0 = (got_q.size() > 0) ? got_q[0] : 32'h0;
    endtask

    initial begin
        int fv;
        int sc;
        logic [31:0] w0;
        logic [31:0] exp0;
        rst_ni = 1'b0;
        bus.start_i = 1'b0; bus.start_col_i = 7'd0; bus.num_adc_i = 8'd0; bus.word_ready_i = 1'b0;
`ifdef OUTBUF_RDCTL_ABORT_EN
        bus.abort_i = 1'b0;
`endif
        for (int i = 0; i < 128; i++) tbl[i] = $urandom;
        for (int i = 0; i < 8; i++) tbl[i] = {tbl[i][31:4], 4'(i)};
        repeat (3) @(negedge clk_i);
        check("reset_outputs", outs_vec(), 64'd0);
        rst_ni = 1'b1;

        run_sweep("full8", 0, 8, 0, fv, w0);
        check("full8_valid_cycle", 64'(fv), 64'd26);
        check("full8_word", 64'(w0), 64'h7654_3210);
        run_sweep("wrap", 126, 3, 0, fv, w0);
        run_sweep("zero", 0, 0, 0, fv, w0);
        run_sweep("clamp", $urandom_range(0, 127), 200, 0, fv, w0);
        for (int r = 0; r < 4; r++)
            run_sweep($sformatf("rand%0d", r), $urandom_range(0, 127), $urandom_range(1, 40), 0, fv, w0);
        run_sweep("stall", $urandom_range(0, 127), 40, 250, fv, w0);

        // Reset in the middle of a sweep.
        bus.word_ready_i = 1'b0;
        @(negedge clk_i);
        bus.start_i = 1'b1; bus.start_col_i = 7'd5; bus.num_adc_i = 8'd16;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("pre_reset_busy", 64'(bus.busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_reset_outputs", outs_vec(), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_sweep("post_reset", $urandom_range(0, 127), $urandom_range(9, 30), 0, fv, w0);

`ifdef OUTBUF_RDCTL_ABORT_EN
        sc = $urandom_range(0, 127);
        exp0 = 32'h0;
        for (int i = 0; i < 8; i++) exp0 = exp0 | ({28'h0, tbl[(sc + i) % 128][3:0]} << (4 * i));
        bus.word_ready_i = 1'b0;
        @(negedge clk_i);
        bus.start_i = 1'b1; bus.start_col_i = sc[6:0]; bus.num_adc_i = 8'd16;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        repeat (29) @(negedge clk_i);
        bus.abort_i = 1'b1;
        @(negedge clk_i);
        bus.abort_i = 1'b0;
        check("abort_pulse", 64'(bus.aborted_o), 64'd1);
        check("abort_busy", 64'(bus.busy_o), 64'd0);
        check("abort_no_done", 64'(bus.done_o), 64'd0);
        check("abort_word_kept", {31'h0, bus.word_valid_o, bus.word_o}, {31'h0, 1'b1, exp0});
        fv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (bus.done_o || bus.aborted_o || bus.read_load_en_o) fv++;
        end
        check("abort_quiet_after", 64'(fv), 64'd0);
        bus.word_ready_i = 1'b1;
        @(negedge clk_i);
        bus.word_ready_i = 1'b0;
        check("abort_fifo_drained", 64'(bus.word_valid_o), 64'd0);
`else
        sc = 0;
        exp0 = 32'h0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/output_buffer_read_ctrl.md
# output_buffer_read_ctrl

Sequencer for the read-mode output buffer of the PIM macro. On a single start command it sweeps a range of ADC slices, drives the buffer's column address, write-enable and load-enable, and collects each 4-bit encoded result. It packs eight results per 32-bit word and queues the words in a small show-ahead FIFO for the RISC-V peripheral bus. It sits between the peripheral register interface and the read-mode output buffer.

## Interface
Parameters:
- FIFO_DEPTH, 4, number of packed words queued (power of two, ≥2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start pulse; sampled only in IDLE
- start_col_i  in  7  first ADC index (0..127)
- num_adc_i  in  8  ADC count; 0 = no-op, values >128 clamped to 128
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at completion
- col_addr9_o  out  9  column address to buffer, {adc_idx, 2'b00}
- read_mode_buf_w_en_o  out  1  buffer capture strobe
- read_load_en_o  out  1  buffer read strobe
- read_mode_encoder_i  in  32  buffer read data; bits [3:0] valid during load
- word_o  out  32  FIFO head word
- word_valid_o  out  1  FIFO not empty
- word_ready_i  in  1  consumer pop; pop occurs when valid & ready

## Operation
- States: IDLE, SEL, WEN, LOAD, PUSH, DONE.
- IDLE: all strobes 0, col_addr9_o = 0. On start_i:
  - num_adc_i = 0: go to DONE.
  - Otherwise: latch start_col and the clamped count, clear the nibble index and pack register, go to SEL.
- SEL: drive col_addr9_o = {adc_idx, 2'b00}; strobes 0 (settle cycle); go to WEN.
- WEN: address held; read_mode_buf_w_en_o = 1; go to LOAD.
- LOAD: address held; read_load_en_o = 1. Capture read_mode_encoder_i[3:0] into pack bits [4k+3:4k], k = nibble index (first ADC of a word at [3:0]). Increment the processed count; adc_idx = (adc_idx + 1) mod 128, wrapping 127 to 0.
  - If k = 7 or the ADC was the last one: go to PUSH.
  - Else: k++ and go to SEL.
- PUSH: if the FIFO is not full, write the pack register. Unfilled nibbles of a partial final word are 0. Then clear the pack register and k.
  - If ADCs remain: go to SEL.
  - Else: go to DONE.
  - If the FIFO is full: hold in PUSH (stall) with no strobes. A pop in the same cycle does not unblock; full is evaluated from registered state.
- DONE: done_o = 1 for one cycle; go to IDLE.
- start_i outside IDLE is ignored.
- The FIFO drains independently of the FSM. Words persist across runs until popped.
- Reset (including mid-sweep): state IDLE, FIFO empty, pack register 0. All outputs 0: busy_o, done_o, strobes, col_addr9_o, word_valid_o, word_o.

## Timing
- The start edge occurs at the end of cycle 0. ADC i (i-th in sweep) occupies SEL/WEN/LOAD in cycles 1+3i+p, 2+3i+p, 3+3i+p, where p = number of PUSH cycles already taken (1 per completed word, plus stall cycles).
- Full 8-ADC word: PUSH in cycle 25; word_valid_o rises in cycle 26.
- Run of N ADCs with no stall: total cycles from start = 3N + ceil(N/8) + 1. done_o is high in the final cycle; busy_o drops the cycle after.
- word_o/word_valid_o are registered FIFO state, updated the cycle after a push or pop.
- Strobes are mutually exclusive and each lasts exactly one cycle per ADC.

## Configuration
- OUTBUF_RDCTL_ABORT_EN defined:
  - Adds input abort_i (1) and output aborted_o (1).
  - abort_i high in any state other than IDLE/DONE forces IDLE on the next edge.
  - The partial pack is discarded; FIFO contents are retained.
  - done_o is not pulsed; aborted_o pulses for one cycle.
  - abort_i has priority over all FSM transitions. aborted_o resets to 0.
- OUTBUF_RDCTL_ABORT_EN undefined: the ports do not exist and a sweep always runs to DONE.

## Test plan
- start_col=0, num=8, buffer returns nibbles 0..7 -> word_o=0x76543210 valid at cycle 26; done_o at cycle 26; col_addr9_o steps 0x000,0x004..0x01C.
- start_col=126, num=3 -> addresses 0x1F8, 0x1FC, 0x000; one word with nibbles [11:0] set and upper 20 bits 0; total cycles 11.
- num=0 -> done_o next cycle, no strobes, no word. num=200 -> exactly 128 ADCs and 16 words pushed.
- word_ready_i=0, FIFO_DEPTH=4, num=40 -> 4 words queued; FSM stalls in PUSH with no strobes; raising ready drains all 5 words in order, then done_o.
- Reset asserted at cycle 10 of a sweep -> all outputs 0 immediately; FIFO empty; a new start runs normally.
- With OUTBUF_RDCTL_ABORT_EN: abort at cycle 30 of num=16 -> first word kept, aborted_o pulses, no done_o, busy_o low next cycle.
